// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if
//   Groups the program-memory bus, the instruction handshake and the branch
//   redirect between the fetch sequencer and its neighbours.
//   master : the fetch sequencer (drives address_bus and instr_*, samples
//            data_bus, instr_ready, redirect and redirect_target).
//   slave  : the memory/consumer side (the mirror image of master).
interface fetch_sequencer_if;
    logic [7:0] address_bus;
    logic [7:0] data_bus;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] instr_opcode;
    logic [7:0] instr_operand;
    logic       instr_len2;
    logic [7:0] instr_pc;
    logic       redirect;
    logic [7:0] redirect_target;

    modport master (
        output address_bus,
        input  data_bus,
        output instr_valid,
        input  instr_ready,
        output instr_opcode,
        output instr_operand,
        output instr_len2,
        output instr_pc,
        input  redirect,
        input  redirect_target
    );

    modport slave (
        input  address_bus,
        output data_bus,
        input  instr_valid,
        output instr_ready,
        input  instr_opcode,
        input  instr_operand,
        input  instr_len2,
        input  instr_pc,
        output redirect,
        output redirect_target
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Fetches one- and two-byte instructions from an 8-bit program memory and
//   presents each complete instruction on a valid/ready handshake. Supports
//   branch redirects, halts on an accepted self-branch and counts accepted
//   instructions with a saturating counter.
//
//   clk          : rising-edge clock for all state
//   reset        : asynchronous active-low reset (0 = in reset)
//   bus          : fetch_sequencer_if.master
//                    address_bus (out, = pc), data_bus (in, combinational),
//                    instr_valid/instr_ready handshake, instr_opcode,
//                    instr_operand, instr_len2, instr_pc (out),
//                    redirect, redirect_target (in)
//   halted       : sticky, set when a self-branch is accepted
//   accept_count : accepted instructions, saturates at 0xFFFF
module fetch_sequencer (
    input  logic                     clk,
    input  logic                     reset,
    fetch_sequencer_if.master        bus,
    output logic                     halted,
    output logic [15:0]              accept_count
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_IMM = 2'd1,
        PRESENT   = 2'd2,
        HALT      = 2'd3
    } state_t;

    localparam logic [7:0] SELF_BRANCH_OP = 8'hA8;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [7:0]  operand_q, operand_d;
    logic [7:0]  ipc_q, ipc_d;
    logic        len2_q, len2_d;
    logic        halted_q, halted_d;
    logic [15:0] accept_cnt_q, accept_cnt_d;

    logic        accept;
    logic        self_branch;

    // MOV_IMM (100000xx), CMP_IMM (100011xx) and the branch group (101xxxxx)
    // carry an immediate byte; everything else is a single byte.
    function automatic logic is_two_byte(input logic [7:0] op);
        return (op[7:2] == 6'b100000) || (op[7:2] == 6'b100011) ||
               (op[7:5] == 3'b101);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign accept      = (state_q == PRESENT) && bus.instr_ready;
    // A branch to its own address can never make progress, so it stops fetch.
    assign self_branch = accept && (opcode_q == SELF_BRANCH_OP) &&
                         (operand_q == ipc_q);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        opcode_d     = opcode_q;
        operand_d    = operand_q;
        ipc_d        = ipc_q;
        len2_d       = len2_q;
        halted_d     = halted_q;
        accept_cnt_d = accept_cnt_q;

        case (state_q)
            FETCH_OP: begin
                opcode_d = bus.data_bus;
                ipc_d    = pc_q;
                pc_d     = pc_q + 8'd1;
                if (is_two_byte(bus.data_bus)) begin
                    state_d = FETCH_IMM;
                end else begin
                    operand_d = 8'h00;
                    len2_d    = 1'b0;
                    state_d   = PRESENT;
                end
            end
            FETCH_IMM: begin
                operand_d = bus.data_bus;
                len2_d    = 1'b1;
                pc_d      = pc_q + 8'd1;
                state_d   = PRESENT;
            end
            PRESENT: begin
                if (accept) begin
                    accept_cnt_d = sat_inc16(accept_cnt_q);
                    if (self_branch) begin
                        state_d  = HALT;
                        halted_d = 1'b1;
                    end else begin
                        state_d = FETCH_OP;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH_OP;
            end
        endcase

        // Redirect wins over fetch progress and over the return to FETCH_OP
        // after an accept (the accept itself is still counted above), but a
        // self-branch accepted in the same cycle halts instead. Whatever was
        // half-fetched is simply abandoned; instr_valid stays low until the
        // new stream produces a complete instruction.
        if (bus.redirect && (state_q != HALT) && !self_branch) begin
            pc_d    = bus.redirect_target;
            state_d = FETCH_OP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH_OP;
            pc_q         <= 8'h00;
            opcode_q     <= 8'h00;
            operand_q    <= 8'h00;
            ipc_q        <= 8'h00;
            len2_q       <= 1'b0;
            halted_q     <= 1'b0;
            accept_cnt_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            opcode_q     <= opcode_d;
            operand_q    <= operand_d;
            ipc_q        <= ipc_d;
            len2_q       <= len2_d;
            halted_q     <= halted_d;
            accept_cnt_q <= accept_cnt_d;
        end
    end

    assign bus.address_bus   = pc_q;
    assign bus.instr_valid   = (state_q == PRESENT);
    assign bus.instr_opcode  = opcode_q;
    assign bus.instr_operand = operand_q;
    assign bus.instr_len2    = len2_q;
    assign bus.instr_pc      = ipc_q;
    assign halted            = halted_q;
    assign accept_count      = accept_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Directed bench for fetch_sequencer. Stimulus pushes the instructions it
//   expects to be accepted into a scoreboard queue; a monitor pops and
//   compares on every accepted handshake. Cycle-exact checks on the bus,
//   halt flag and counter are made from the stimulus thread.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        halted;
    logic [15:0] accept_count;
    logic [7:0]  mem [256];

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] opnd;
        logic       len2;
        logic [7:0] pc;
    } instr_t;

    instr_t sb[$];
    instr_t got, want;

    int n_checks = 0;
    int n_errors = 0;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .halted       (halted),
        .accept_count (accept_count)
    );

    always #5 clk = ~clk;

    assign bus.data_bus = mem[bus.address_bus];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        chk(name, 64'(act), 64'(exp));
    endtask

    task automatic expect_instr(input logic [7:0] op, input logic [7:0] opnd,
                                input logic len2, input logic [7:0] pc);
        instr_t e;
        e.op   = op;
        e.opnd = opnd;
        e.len2 = len2;
        e.pc   = pc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the block in reset with a blank (all 0x00) program loaded.
    task automatic begin_test();
        reset               = 1'b0;
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        tick();
    endtask

    task automatic go();
        reset = 1'b1;
    endtask

    // Scoreboard monitor: every accepted handshake must match the next entry.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) begin
            got.op   = bus.instr_opcode;
            got.opnd = bus.instr_operand;
            got.len2 = bus.instr_len2;
            got.pc   = bus.instr_pc;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got op=%h opnd=%h len2=%b pc=%h, none expected",
                         got.op, got.opnd, got.len2, got.pc);
            end else begin
                want = sb.pop_front();
                chk("sb_instr", 64'(got), 64'(want));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.instr_ready     = 1'b0;
        bus.redirect        = 1'b0;
        bus.redirect_target = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        #12;

        // Reset state
        chk8 ("rst_addr",    bus.address_bus,   8'h00);
        chk1 ("rst_valid",   bus.instr_valid,   1'b0);
        chk8 ("rst_opcode",  bus.instr_opcode,  8'h00);
        chk8 ("rst_operand", bus.instr_operand, 8'h00);
        chk1 ("rst_len2",    bus.instr_len2,    1'b0);
        chk8 ("rst_pc",      bus.instr_pc,      8'h00);
        chk1 ("rst_halted",  halted,            1'b0);
        chk16("rst_count",   accept_count,      16'h0000);

        // Two-byte fetch, then a one-byte instruction from address 0x02
        begin_test();
        mem[0] = 8'h81; mem[1] = 8'h00; mem[2] = 8'h04;
        bus.instr_ready = 1'b1;
        expect_instr(8'h81, 8'h00, 1'b1, 8'h00);
        expect_instr(8'h04, 8'h00, 1'b0, 8'h02);
        go();
        tick();
        chk1 ("a_valid_e1", bus.instr_valid, 1'b0);
        chk8 ("a_addr_e1",  bus.address_bus, 8'h01);
        tick();
        chk1 ("a_valid_e2", bus.instr_valid, 1'b1);
        chk ("a_instr_e2", 64'({bus.instr_opcode, bus.instr_operand, bus.instr_len2, bus.instr_pc}),
             64'({8'h81, 8'h00, 1'b1, 8'h00}));
        chk8 ("a_addr_e2",  bus.address_bus, 8'h02);
        tick();
        chk1 ("a_valid_e3", bus.instr_valid, 1'b0);
        chk8 ("a_addr_e3",  bus.address_bus, 8'h02);
        chk16("a_count_e3", accept_count,    16'd1);
        tick();
        chk8 ("a_addr_e4",  bus.address_bus, 8'h03);
        tick();
        chk16("a_count_e5", accept_count,    16'd2);
        bus.instr_ready = 1'b0;

        // Backpressure on a one-byte instruction at 0x04
        begin_test();
        mem[4] = 8'h98;
        bus.redirect = 1'b1; bus.redirect_target = 8'h04;
        expect_instr(8'h98, 8'h00, 1'b0, 8'h04);
        go();
        tick();
        bus.redirect = 1'b0;
        chk8 ("b_addr_e1", bus.address_bus, 8'h04);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("b_hold", 64'({bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_len2,
                               bus.instr_pc, bus.address_bus, accept_count}),
                64'({1'b1, 8'h98, 8'h00, 1'b0, 8'h04, 8'h05, 16'h0000}));
            tick();
        end
        chk("b_hold_last", 64'({bus.instr_valid, bus.instr_opcode, bus.instr_pc}),
            64'({1'b1, 8'h98, 8'h04}));
        bus.instr_ready = 1'b1;
        tick();
        chk16("b_count", accept_count,    16'd1);
        chk8 ("b_addr",  bus.address_bus, 8'h05);
        bus.instr_ready = 1'b0;

        // Redirect during FETCH_IMM discards the BEQ at 0x09
        begin_test();
        mem[8'h09] = 8'hB4; mem[8'h0A] = 8'h55; mem[8'h0D] = 8'h10;
        bus.redirect = 1'b1; bus.redirect_target = 8'h09;
        bus.instr_ready = 1'b1;
        expect_instr(8'h10, 8'h00, 1'b0, 8'h0D);
        go();
        tick();
        bus.redirect = 1'b0;
        tick();
        chk8 ("c_addr_imm", bus.address_bus, 8'h0A);
        bus.redirect = 1'b1; bus.redirect_target = 8'h0D;
        tick();
        bus.redirect = 1'b0;
        chk1 ("c_valid_redir", bus.instr_valid, 1'b0);
        chk8 ("c_addr_redir",  bus.address_bus, 8'h0D);
        tick();
        chk1 ("c_valid", bus.instr_valid, 1'b1);
        chk8 ("c_pc",    bus.instr_pc,    8'h0D);
        tick();
        bus.instr_ready = 1'b0;
        chk16("c_count", accept_count,    16'd1);

        // Wrap-around: two-byte opcode at 0xFF takes its operand from 0x00
        begin_test();
        mem[8'hFF] = 8'hA8; mem[8'h00] = 8'h04;
        bus.redirect = 1'b1; bus.redirect_target = 8'hFF;
        expect_instr(8'hA8, 8'h04, 1'b1, 8'hFF);
        go();
        tick();
        bus.redirect = 1'b0;
        chk8 ("d_addr_ff", bus.address_bus, 8'hFF);
        tick();
        chk8 ("d_addr_wrap", bus.address_bus, 8'h00);
        tick();
        chk ("d_instr", 64'({bus.instr_valid, bus.instr_opcode, bus.instr_operand, bus.instr_len2, bus.instr_pc}),
             64'({1'b1, 8'hA8, 8'h04, 1'b1, 8'hFF}));
        chk8 ("d_addr_after", bus.address_bus, 8'h01);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        chk8 ("d_addr_next", bus.address_bus, 8'h01);
        chk1 ("d_halted",    halted,          1'b0);

        // Accept and redirect in the same cycle
        begin_test();
        mem[8'h00] = 8'h04; mem[8'h20] = 8'h05;
        expect_instr(8'h04, 8'h00, 1'b0, 8'h00);
        expect_instr(8'h05, 8'h00, 1'b0, 8'h20);
        go();
        tick();
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_target = 8'h20;
        tick();
        bus.redirect = 1'b0;
        chk16("e_count1", accept_count,    16'd1);
        chk8 ("e_addr",   bus.address_bus, 8'h20);
        chk1 ("e_valid",  bus.instr_valid, 1'b0);
        tick();
        chk8 ("e_pc", bus.instr_pc, 8'h20);
        tick();
        bus.instr_ready = 1'b0;
        chk16("e_count2", accept_count, 16'd2);

        // Self-branch halt; a simultaneous redirect loses to the halt
        begin_test();
        mem[8'h32] = 8'hA8; mem[8'h33] = 8'h32;
        bus.redirect = 1'b1; bus.redirect_target = 8'h32;
        expect_instr(8'hA8, 8'h32, 1'b1, 8'h32);
        go();
        tick();
        bus.redirect = 1'b0;
        tick();
        tick();
        chk1 ("f_valid", bus.instr_valid, 1'b1);
        bus.instr_ready = 1'b1;
        bus.redirect = 1'b1; bus.redirect_target = 8'h40;
        tick();
        chk ("f_halt", 64'({halted, bus.instr_valid, bus.address_bus, accept_count}),
             64'({1'b1, 1'b0, 8'h34, 16'd1}));
        for (int k = 0; k < 4; k++) begin
            bus.redirect = k[0];
            bus.redirect_target = 8'h10;
            tick();
            chk("f_halt_hold", 64'({halted, bus.instr_valid, bus.address_bus}),
                64'({1'b1, 1'b0, 8'h34}));
        end
        #2;
        reset = 1'b0;
        #1;
        chk ("f_async_rst", 64'({halted, bus.instr_valid, bus.address_bus, accept_count}),
             64'({1'b0, 1'b0, 8'h00, 16'd0}));

        // Saturating accept counter, preloaded just below the limit
        begin_test();
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) expect_instr(8'h00, 8'h00, 1'b0, 8'(i));
        go();
        force dut.accept_cnt_q = 16'hFFFD;
        #1;
        release dut.accept_cnt_q;
        tick();
        tick();
        chk16("g_count_fffe", accept_count, 16'hFFFE);
        tick();
        tick();
        chk16("g_count_ffff", accept_count, 16'hFFFF);
        tick();
        tick();
        chk16("g_count_hold1", accept_count, 16'hFFFF);
        tick();
        tick();
        chk16("g_count_hold2", accept_count, 16'hFFFF);
        bus.instr_ready = 1'b0;

        // Asynchronous reset in the middle of a two-byte fetch
        begin_test();
        mem[0] = 8'h81;
        go();
        tick();
        chk8 ("h_opcode_pre", bus.instr_opcode, 8'h81);
        #2;
        reset = 1'b0;
        #1;
        chk ("h_async_rst", 64'({bus.instr_opcode, bus.instr_pc, bus.address_bus, bus.instr_valid, bus.instr_len2}),
             64'({8'h00, 8'h00, 8'h00, 1'b0, 1'b0}));

        chk ("sb_drained", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-004 address_bus  output  8  program memory address, driven from a register.
REQ-005 data_bus  input  8  program memory byte, combinational in the same cycle as address_bus.
REQ-006 instr_valid  output  1  a complete instruction is presented.
REQ-007 instr_ready  input  1  consumer accepts the presented instruction.
REQ-008 instr_opcode  output  8  first instruction byte.
REQ-009 instr_operand  output  8  second byte; 0x00 for one-byte instructions.
REQ-010 instr_len2  output  1  1 = two-byte instruction.
REQ-011 instr_pc  output  8  address of instr_opcode.
REQ-012 redirect  input  1  branch taken; restart fetch at redirect_target.
REQ-013 redirect_target  input  8  new fetch address.
REQ-014 halted  output  1  sticky flag: a self-branch was accepted.
REQ-015 accept_count  output  16  number of accepted instructions, saturating.

Function
REQ-016 Length decode SHALL be as follows: an opcode is two bytes when op[7:2] is 100000 (MOV_IMM) or 100011 (CMP_IMM), or when op[7:5] is 101 (BRA, BHI, BEQ); every other opcode is one byte.
REQ-017 The FSM SHALL have the states FETCH_OP, FETCH_IMM, PRESENT and HALT.
REQ-018 In FETCH_OP, the block SHALL register data_bus into instr_opcode, register address_bus into instr_pc, and increment pc by 1.
REQ-019 From FETCH_OP, a two-byte opcode SHALL go to FETCH_IMM; a one-byte opcode SHALL go to PRESENT with instr_operand=0x00 and instr_len2=0.
REQ-020 In FETCH_IMM, the block SHALL register data_bus into instr_operand, set instr_len2=1, increment pc by 1, and go to PRESENT.
REQ-021 Latency from entering FETCH_OP to instr_valid=1 SHALL be 1 cycle for one-byte instructions and 2 cycles for two-byte instructions.
REQ-022 instr_valid SHALL be 1 exactly when in PRESENT.
REQ-023 All instr_* outputs SHALL stay stable while instr_valid=1 and instr_ready=0.
REQ-024 An accept SHALL be a cycle with instr_valid=1 and instr_ready=1; on accept, accept_count SHALL increment (holding at 0xFFFF) and the FSM SHALL go to FETCH_OP at the current pc.
REQ-025 A self-branch SHALL be an accepted instruction with instr_opcode=0xA8 and instr_operand=instr_pc.
REQ-026 On a self-branch accept, the FSM SHALL go to HALT and set halted=1 instead of going to FETCH_OP.
REQ-027 In HALT, the block SHALL hold instr_valid=0 and address_bus, ignore redirect, and leave HALT only by reset.
REQ-028 Outside HALT, redirect=1 SHALL have priority over every other event in any state: pc <= redirect_target, instr_valid=0 next cycle, next state FETCH_OP.
REQ-029 Any partially fetched instruction SHALL be discarded on redirect.
REQ-030 redirect and accept in the same cycle SHALL count the accept, then redirect; a self-branch check in that cycle SHALL take precedence over the redirect.
REQ-031 pc arithmetic SHALL be modulo 256: pc 0xFF + 1 = 0x00.
REQ-032 A two-byte opcode at 0xFF SHALL take its operand from address 0x00.
REQ-033 address_bus SHALL always equal pc.

Reset
REQ-034 While reset=0, the block SHALL hold pc=0x00, state FETCH_OP, instr_valid=0, instr_opcode=0x00, instr_operand=0x00, instr_len2=0, instr_pc=0x00, halted=0 and accept_count=0.
REQ-035 Fetching SHALL begin at the first rising clk edge after reset goes to 1; the program memory loads its contents while reset=0.
REQ-036 Asserting reset mid-fetch or in HALT SHALL return the block to the REQ-034 values immediately, without waiting for a clock edge.

Verification
REQ-037 Two-byte fetch: memory[0..1]=0x81,0x00, instr_ready=1 -> instr_valid=1 on the 2nd cycle after reset release with opcode 0x81, operand 0x00, len2=1, pc 0x00; the next fetch starts at address 0x02.
REQ-038 Backpressure on a one-byte instruction: memory[4]=0x98, instr_ready=0 for 5 cycles -> outputs held at opcode 0x98, pc 0x04, len2=0; on accept, accept_count increments by 1 and address_bus=0x05.
REQ-039 Mid-fetch redirect: BEQ 0xB4 fetched at 0x09, redirect=1 with target 0x0D during FETCH_IMM -> no valid instruction for 0x09; next instr_pc=0x0D.
REQ-040 Wrap-around: memory[0xFF]=0xA8, memory[0x00]=0x04 -> instr_pc=0xFF, operand 0x04, pc=0x01 afterwards.
REQ-041 Self-branch halt: memory[50..51]=0xA8,0x32, accepted -> halted=1, instr_valid=0 forever; redirect pulses ignored; reset=0 clears halted asynchronously.
REQ-042 Saturation: force 65 536 accepts -> accept_count holds at 0xFFFF.
